// File: rtl/nor_chain_stim_gen.sv
// Burst stimulus generator for the NOR-chain inputs: counted A1 pulses, A2 replays A1 edges after a skew.
// Optional macro STIM_PULSE_CNT_EN adds the PULSE_CNT output (completed-pulse counter).
module nor_chain_stim_gen #(
   parameter int CNT_W = 16,
   parameter int NP_W  = 8
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             START,
   input  logic             ABORT,
   input  logic [CNT_W-1:0] HIGH_LEN,
   input  logic [CNT_W-1:0] LOW_LEN,
   input  logic [CNT_W-1:0] SKEW,
   input  logic [NP_W-1:0]  NUM_PULSES,
   output logic             BUSY,
   output logic             DONE,
   output logic             A1,
`ifdef STIM_PULSE_CNT_EN
   output logic [NP_W-1:0]  PULSE_CNT,
`endif
   output logic             A2
);

   typedef enum logic [1:0] {IDLE, HIGH, LOW, FIN} state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] phase_cnt_q, phase_cnt_d;
   logic [CNT_W-1:0] skew_cnt_q, skew_cnt_d;
   logic [CNT_W-1:0] high_q, high_d;
   logic [CNT_W-1:0] low_q, low_d;
   logic [CNT_W-1:0] skew_q, skew_d;
   logic [NP_W-1:0]  pulses_q, pulses_d;
   logic [NP_W-1:0]  pulse_cnt_q, pulse_cnt_d;
   logic             a1_q, a1_d, a2_q, a2_d, busy_q, busy_d, done_q, done_d;

   logic [CNT_W-1:0] eff_high, eff_low, eff_skew, skew_lim, skew_sel;
   logic             launch, abort_hit, phase_done;

   // Clamp computed from the live inputs; only used in the launch cycle.
   assign eff_high = (HIGH_LEN == '0) ? CNT_W'(1) : HIGH_LEN;
   assign eff_low  = (LOW_LEN == '0) ? CNT_W'(1) : LOW_LEN;
   assign skew_lim = ((eff_high < eff_low) ? eff_high : eff_low) - CNT_W'(1);
   assign eff_skew = (SKEW > skew_lim) ? skew_lim : SKEW;

   assign launch     = (state_q == IDLE) && START && (NUM_PULSES != '0);
   assign abort_hit  = (state_q != IDLE) && ABORT;
   assign phase_done = (phase_cnt_q == '0);
   assign skew_sel   = launch ? eff_skew : skew_q;

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q     <= IDLE;
         phase_cnt_q <= '0;
         skew_cnt_q  <= '0;
         high_q      <= '0;
         low_q       <= '0;
         skew_q      <= '0;
         pulses_q    <= '0;
         pulse_cnt_q <= '0;
         a1_q        <= 1'b0;
         a2_q        <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         phase_cnt_q <= phase_cnt_d;
         skew_cnt_q  <= skew_cnt_d;
         high_q      <= high_d;
         low_q       <= low_d;
         skew_q      <= skew_d;
         pulses_q    <= pulses_d;
         pulse_cnt_q <= pulse_cnt_d;
         a1_q        <= a1_d;
         a2_q        <= a2_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
      end
   end

   // NOTE: every comb output gets a default first, so no path can infer a latch.
   always_comb begin
      state_d = state_q;
      if (abort_hit) begin
         state_d = IDLE;
      end else begin
         unique case (state_q)
            IDLE:    if (launch) state_d = HIGH;
            HIGH:    if (phase_done) state_d = LOW;
            LOW:     if (phase_done) state_d = (pulses_q == NP_W'(1)) ? FIN : HIGH;
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
         endcase
      end
   end

   always_comb begin
      phase_cnt_d = phase_cnt_q;
      skew_cnt_d  = skew_cnt_q;
      high_d      = high_q;
      low_d       = low_q;
      skew_d      = skew_q;
      pulses_d    = pulses_q;
      pulse_cnt_d = pulse_cnt_q;
      a2_d        = a2_q;

      // Output flops follow the next state, so A1/BUSY/DONE change on the transition edge.
      a1_d   = (state_d == HIGH);
      busy_d = (state_d == HIGH) || (state_d == LOW);
      done_d = (state_d == FIN);

      if (abort_hit) begin
         phase_cnt_d = '0;
         skew_cnt_d  = '0;
         pulses_d    = '0;
         a2_d        = 1'b0;
      end else begin
         if (launch) begin
            high_d      = eff_high;
            low_d       = eff_low;
            skew_d      = eff_skew;
            pulses_d    = NUM_PULSES;
            pulse_cnt_d = '0;
            phase_cnt_d = eff_high - CNT_W'(1);
         end else if (state_q == HIGH) begin
            phase_cnt_d = phase_done ? (low_q - CNT_W'(1)) : (phase_cnt_q - CNT_W'(1));
         end else if (state_q == LOW) begin
            if (phase_done) begin
               pulses_d    = pulses_q - NP_W'(1);
               pulse_cnt_d = pulse_cnt_q + NP_W'(1);
               phase_cnt_d = high_q - CNT_W'(1);
            end else begin
               phase_cnt_d = phase_cnt_q - CNT_W'(1);
            end
         end

         // The clamp guarantees a pending A2 edge always lands before the next A1 edge.
         if (a1_d != a1_q) begin
            if (skew_sel == '0) a2_d = a1_d;
            else skew_cnt_d = skew_sel;
         end else if (skew_cnt_q != '0) begin
            skew_cnt_d = skew_cnt_q - CNT_W'(1);
            if (skew_cnt_q == CNT_W'(1)) a2_d = a1_q;
         end
      end
   end

   assign A1   = a1_q;
   assign A2   = a2_q;
   assign BUSY = busy_q;
   assign DONE = done_q;
`ifdef STIM_PULSE_CNT_EN
   assign PULSE_CNT = pulse_cnt_q;
`endif

endmodule

// File: tb/tb_nor_chain_stim_gen.sv
// Directed bench for nor_chain_stim_gen: per-cycle A1/A2/BUSY/DONE traces against hand-derived patterns.
module tb_nor_chain_stim_gen;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic        abort = 1'b0;
   logic [15:0] high_len = '0, low_len = '0, skew = '0;
   logic [7:0]  num_pulses = '0;
   logic        busy, done, a1, a2;
`ifdef STIM_PULSE_CNT_EN
   logic [7:0]  pulse_cnt;
`endif

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   nor_chain_stim_gen #(.CNT_W(16), .NP_W(8)) dut (
      .CLK        (clk),
      .RST        (rst),
      .START      (start),
      .ABORT      (abort),
      .HIGH_LEN   (high_len),
      .LOW_LEN    (low_len),
      .SKEW       (skew),
      .NUM_PULSES (num_pulses),
      .BUSY       (busy),
      .DONE       (done),
      .A1         (a1),
`ifdef STIM_PULSE_CNT_EN
      .PULSE_CNT  (pulse_cnt),
`endif
      .A2         (a2)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %b expected %b", tag, got, exp);
      end
   endtask

   task automatic launch(input logic [15:0] h, l, s, input logic [7:0] n);
      @(negedge clk);
      high_len = h; low_len = l; skew = s; num_pulses = n; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   // Traces are shifted in cycle by cycle, so the first cycle after START is the MSB.
   task automatic run_burst(input string tag, input logic [15:0] h, l, s, input logic [7:0] n,
                            input int len, input logic [31:0] e_a1, e_a2, e_busy, e_done);
      logic [31:0] o_a1, o_a2, o_busy, o_done;
      o_a1 = '0; o_a2 = '0; o_busy = '0; o_done = '0;
      launch(h, l, s, n);
      for (int k = 0; k < len; k++) begin
         if (k > 0) @(negedge clk);
         o_a1   = {o_a1[30:0], a1};
         o_a2   = {o_a2[30:0], a2};
         o_busy = {o_busy[30:0], busy};
         o_done = {o_done[30:0], done};
      end
      check({tag, ".a1"}, o_a1, e_a1);
      check({tag, ".a2"}, o_a2, e_a2);
      check({tag, ".busy"}, o_busy, e_busy);
      check({tag, ".done"}, o_done, e_done);
   endtask

   initial begin
      logic seen;
      repeat (2) @(negedge clk);
      check("rst.a1", {31'b0, a1}, 32'd0);
      check("rst.a2", {31'b0, a2}, 32'd0);
      check("rst.busy", {31'b0, busy}, 32'd0);
      check("rst.done", {31'b0, done}, 32'd0);
      rst = 1'b0;

      // 3 high / 5 low, no skew, 2 pulses: DONE in cycle 17, BUSY for 16 cycles.
      run_burst("b3_5_s0", 16'd3, 16'd5, 16'd0, 8'd2, 18,
                32'b111000001110000000, 32'b111000001110000000,
                32'b111111111111111100, 32'b000000000000000010);
`ifdef STIM_PULSE_CNT_EN
      check("b3_5_s0.pulse_cnt", {24'b0, pulse_cnt}, 32'd2);
`endif

      // Skew 2 on a 4/4 pulse: A2 trails A1 by two cycles on both edges.
      run_burst("b4_4_s2", 16'd4, 16'd4, 16'd2, 8'd1, 10,
                32'b1111000000, 32'b0011110000, 32'b1111111100, 32'b0000000010);

      // Skew 9 clamps to min(2,6)-1 = 1.
      run_burst("b2_6_s9", 16'd2, 16'd6, 16'd9, 8'd1, 10,
                32'b1100000000, 32'b0110000000, 32'b1111111100, 32'b0000000010);

      // Zero pulse count: START ignored, everything stays low.
      run_burst("np0", 16'd3, 16'd3, 16'd0, 8'd0, 5,
                32'b0, 32'b0, 32'b0, 32'b0);

      // HIGH_LEN=0 behaves as 1.
      run_burst("h0", 16'd0, 16'd2, 16'd0, 8'd1, 6,
                32'b100000, 32'b100000, 32'b111000, 32'b000100);

      // Abort during the second HIGH phase of a 5-pulse 2/2 burst (cycle 5).
      launch(16'd2, 16'd2, 16'd1, 8'd5);
      repeat (4) @(negedge clk);
      check("abort.pre_a1", {31'b0, a1}, 32'd1);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      check("abort.a1", {31'b0, a1}, 32'd0);
      check("abort.a2", {31'b0, a2}, 32'd0);
      check("abort.busy", {31'b0, busy}, 32'd0);
      check("abort.done", {31'b0, done}, 32'd0);
`ifdef STIM_PULSE_CNT_EN
      check("abort.pulse_cnt", {24'b0, pulse_cnt}, 32'd1);
`endif
      seen = 1'b0;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         seen = seen | done | busy | a1 | a2;
      end
      check("abort.quiet", {31'b0, seen}, 32'd0);

      run_burst("post_abort", 16'd3, 16'd5, 16'd0, 8'd2, 18,
                32'b111000001110000000, 32'b111000001110000000,
                32'b111111111111111100, 32'b000000000000000010);

      // Asynchronous reset during HIGH clears outputs before any clock edge.
      launch(16'd6, 16'd2, 16'd0, 8'd1);
      @(negedge clk);
      check("arst.pre_a1", {31'b0, a1}, 32'd1);
      #1 rst = 1'b1;
      #1;
      check("arst.a1", {31'b0, a1}, 32'd0);
      check("arst.a2", {31'b0, a2}, 32'd0);
      check("arst.busy", {31'b0, busy}, 32'd0);
      check("arst.done", {31'b0, done}, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      repeat (3) @(negedge clk);
      check("arst.idle_busy", {31'b0, busy}, 32'd0);

      run_burst("post_rst", 16'd4, 16'd4, 16'd2, 8'd1, 10,
                32'b1111000000, 32'b0011110000, 32'b1111111100, 32'b0000000010);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/nor_chain_stim_gen.md
Name: nor_chain_stim_gen

Overview:
Programmable digital stimulus generator that drives the two primary inputs (A1, A2) of the parallel NOR-chain delay lines under evaluation. It emits a counted burst of pulses on A1. A2 copies A1's edges after a programmable cycle skew, which exercises the single-input-switching and multi-input-switching cases of the NOR2 first stage. It sits directly upstream of the chain; its A1/A2 outputs connect straight to the chain inputs.

Parameters:
CNT_W, 16, width of the pulse high, pulse low and skew length fields (cycles)
NP_W, 8, width of the pulse-count field

Ports:
CLK  input  1  single clock; all state updates on the rising edge
RST  input  1  asynchronous, active-high reset
START  input  1  one-cycle request to launch a burst; sampled only in IDLE
ABORT  input  1  terminates a running burst
HIGH_LEN  input  CNT_W  A1 high time in cycles; 0 is treated as 1
LOW_LEN  input  CNT_W  A1 low time in cycles; 0 is treated as 1
SKEW  input  CNT_W  delay in cycles from each A1 edge to the matching A2 edge
NUM_PULSES  input  NP_W  number of A1 pulses in the burst
BUSY  output  1  high while a burst is in progress
DONE  output  1  one-cycle pulse when a burst completes normally
A1  output  1  stimulus to chain input A1
A2  output  1  stimulus to chain input A2

Behaviour:
- Reset (asynchronous, RST=1): state IDLE, all counters 0; A1=0, A2=0, BUSY=0, DONE=0.
- FSM states: IDLE, HIGH, LOW, FIN.
- IDLE:
  - START=1 and NUM_PULSES!=0: latch HIGH_LEN, LOW_LEN, SKEW and NUM_PULSES. Next cycle the state is HIGH, A1=1 and BUSY=1.
  - START=1 and NUM_PULSES==0: ignored; no BUSY, no DONE.
- Skew clamp at latch time:
  - eff_skew = min(SKEW, min(eff_high, eff_low) - 1), where eff_x = max(x, 1).
  - This guarantees at most one pending A2 edge at any time.
- HIGH: A1=1 for exactly eff_high cycles, then the state moves to LOW (A1=0).
- LOW: A1=0 for exactly eff_low cycles.
  - At expiry the remaining pulse count is decremented.
  - If pulses remain, go to HIGH; otherwise go to FIN.
- A2 timing:
  - Every A1 toggle loads a skew counter with eff_skew.
  - A2 toggles eff_skew cycles after the A1 toggle.
  - With eff_skew=0, A2 toggles in the same cycle as A1, so A2 is identical to A1.
- FIN: lasts one cycle. DONE=1, BUSY=0 and A1=A2=0 are already settled. The next state is IDLE.
  - Latency from START to DONE = 1 + N*(eff_high + eff_low) cycles.
- START while BUSY: ignored. The latched configuration never changes mid-burst.
- ABORT=1 in any non-IDLE state: the next cycle is IDLE with A1=0, A2=0, BUSY=0, DONE=0 and the skew counter cleared. ABORT outranks START and the phase-expiry transitions in the same cycle. ABORT in IDLE has no effect.
- Counter arithmetic: unsigned CNT_W-bit down-counters with no wrap. Max burst length is 255 pulses; a phase is at most 65535 cycles.
- All outputs are registered; there are no combinational paths from inputs to outputs.

Optional Feature:
Macro STIM_PULSE_CNT_EN.
- Defined: adds output PULSE_CNT (NP_W bits), which counts completed A1 pulses (each counted at LOW expiry).
  - Cleared to 0 by reset and when a burst launches.
  - Holds its final value after DONE or ABORT until the next launch.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- Reset mid-burst: assert RST during HIGH -> A1=A2=BUSY=DONE=0 immediately, without waiting for a clock edge; the FSM is in IDLE after release.
- HIGH_LEN=3, LOW_LEN=5, SKEW=0, NUM_PULSES=2, START -> A1 pattern 11100000 repeated twice; A2 identical to A1; DONE asserts 17 cycles after START; BUSY high for 16 cycles.
- HIGH_LEN=4, LOW_LEN=4, SKEW=2, NUM_PULSES=1 -> A2 rises 2 cycles after A1 rises and falls 2 cycles after A1 falls; DONE 9 cycles after START.
- HIGH_LEN=2, LOW_LEN=6, SKEW=9, NUM_PULSES=1 -> eff_skew clamps to 1; A2 lags A1 by 1 cycle on both edges.
- NUM_PULSES=0 with START -> BUSY and DONE stay 0; A1 and A2 stay 0. HIGH_LEN=0 -> A1 high for 1 cycle.
- ABORT asserted during the 2nd pulse of a 5-pulse burst (with STIM_PULSE_CNT_EN) -> A1=A2=0 next cycle, no DONE, PULSE_CNT=1; a subsequent START launches cleanly.
